decode_stage: RTL and testbench

Parametrised, multi-lane successor to the single-instruction decode register. Accepts a fetch group of `LANES` instructions per cycle over a valid/ready handshake, decodes each lane with one `decode_unit`, computes per-lane shadow status from in-group and in-flight branches, and buffers decoded groups in a 2-entry output queue. It sits between fetch and rename/dispatch and owns the in-flight branch count used for shadow marking and branch-limit stalling.

---
 rtl/decode_stage.sv | 236 +++++++++++++++++++++++
 tb/tb_decode_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Multi-lane decode stage: decodes a fetch group, marks branch shadows, tracks
// in-flight branches and buffers decoded groups in a two-entry output queue.

package uopc;
    typedef enum logic [3:0] {
        UOP_NOP, UOP_ADD, UOP_SUB, UOP_ALU, UOP_ADDI, UOP_ALUI, UOP_LUI,
        UOP_AUIPC, UOP_LD, UOP_ST, UOP_BR, UOP_JAL, UOP_JALR
    } micro_opcode_t;
endpackage

package iqt;
    typedef enum logic [1:0] {IQT_NONE, IQT_INT, IQT_MEM} queue_type_t;
endpackage

package exut;
    typedef enum logic [1:0] {EXU_NONE, EXU_ALU, EXU_BRU, EXU_LSU} exe_unit_type_t;
endpackage

package immt;
    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_t;
endpackage

package decode_pkg;
    typedef struct packed {
        uopc::micro_opcode_t  uopcode;
        iqt::queue_type_t     iq_type;
        exut::exe_unit_type_t exu_type;
        immt::imm_type_t      imm_type;
        logic has_rd, has_rs1, has_rs2, is_br, is_jal, is_jalr;
        logic [19:0] packed_imm;
    } dec_t;
endpackage

// Single-instruction RV32I decoder; unknown opcodes decode to an all-zero NOP.
module decode_unit (
    input  logic [31:0]       instr,
    output decode_pkg::dec_t  dec
);
    import uopc::*; import iqt::*; import exut::*; import immt::*;

    always_comb begin
        // NOTE: full default first so no path through the case leaves a field unassigned (no latches).
        dec = '0;
        case (instr[6:0])
            7'b0110011: begin
                dec.uopcode = (instr[14:12] != 3'b000) ? UOP_ALU : (instr[30] ? UOP_SUB : UOP_ADD);
                {dec.iq_type, dec.exu_type} = {IQT_INT, EXU_ALU};
                {dec.has_rd, dec.has_rs1, dec.has_rs2} = 3'b111;
            end
            7'b0010011: begin
                dec.uopcode = (instr[14:12] == 3'b000) ? UOP_ADDI : UOP_ALUI;
                {dec.iq_type, dec.exu_type, dec.imm_type} = {IQT_INT, EXU_ALU, IMM_I};
                {dec.has_rd, dec.has_rs1} = 2'b11;
            end
            7'b0110111, 7'b0010111: begin
                dec.uopcode = instr[5] ? UOP_LUI : UOP_AUIPC;
                {dec.iq_type, dec.exu_type, dec.imm_type} = {IQT_INT, EXU_ALU, IMM_U};
                dec.has_rd = 1'b1;
            end
            7'b0000011: begin
                dec.uopcode = UOP_LD;
                {dec.iq_type, dec.exu_type, dec.imm_type} = {IQT_MEM, EXU_LSU, IMM_I};
                {dec.has_rd, dec.has_rs1} = 2'b11;
            end
            7'b0100011: begin
                dec.uopcode = UOP_ST;
                {dec.iq_type, dec.exu_type, dec.imm_type} = {IQT_MEM, EXU_LSU, IMM_S};
                {dec.has_rs1, dec.has_rs2} = 2'b11;
            end
            7'b1100011: begin
                dec.uopcode = UOP_BR;
                {dec.iq_type, dec.exu_type, dec.imm_type} = {IQT_INT, EXU_BRU, IMM_B};
                {dec.has_rs1, dec.has_rs2, dec.is_br} = 3'b111;
            end
            7'b1101111: begin
                dec.uopcode = UOP_JAL;
                {dec.iq_type, dec.exu_type, dec.imm_type} = {IQT_INT, EXU_BRU, IMM_J};
                {dec.has_rd, dec.is_jal} = 2'b11;
            end
            7'b1100111: begin
                dec.uopcode = UOP_JALR;
                {dec.iq_type, dec.exu_type, dec.imm_type} = {IQT_INT, EXU_BRU, IMM_I};
                {dec.has_rd, dec.has_rs1, dec.is_jalr} = 3'b111;
            end
            default: ;
        endcase
        // 12-bit immediates sit in the top bits; U/J keep their full 20-bit field
        case (dec.imm_type)
            IMM_I:        dec.packed_imm = {instr[31:20], 8'h00};
            IMM_S, IMM_B: dec.packed_imm = {instr[31:25], instr[11:7], 8'h00};
            IMM_U, IMM_J: dec.packed_imm = instr[31:12];
            default:      dec.packed_imm = '0;
        endcase
    end
endmodule

module decode_stage #(
    parameter int  LANES  = 2,
    parameter int  MAX_BR = 4,
    localparam int BW     = $clog2(MAX_BR + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES-1:0]        in_lane_valid,
    input  logic [32*LANES-1:0]     in_instr,
    input  logic [31:0]             in_pc,
    input  logic                    in_under_shadow,
    input  logic                    br_resolve,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES-1:0]        out_lane_valid,
    output logic [32*LANES-1:0]     out_pc,
    output uopc::micro_opcode_t     out_uopcode [LANES],
    output iqt::queue_type_t        out_iq_type [LANES],
    output exut::exe_unit_type_t    out_exu_type [LANES],
    output immt::imm_type_t         out_imm_type [LANES],
    output logic                    out_has_rd [LANES],
    output logic                    out_has_rs1 [LANES],
    output logic                    out_has_rs2 [LANES],
    output logic                    out_is_br [LANES],
    output logic                    out_is_jal [LANES],
    output logic                    out_is_jalr [LANES],
    output logic                    out_shadowed [LANES],
    output logic [19:0]             out_packed_imm [LANES],
    output logic [BW-1:0]           br_inflight
);
    localparam int GW = $clog2(LANES + 1);
    localparam int PW = BW + GW + 1;

    decode_pkg::dec_t    lane_dec [LANES];
    decode_pkg::dec_t    new_dec [LANES];
    logic [LANES-1:0]    new_sh;
    logic [32*LANES-1:0] new_pc;
    logic [GW-1:0]       grp_br;
    logic                prior_br, resolve_eff, accept, pop;
    logic [PW-1:0]       br_settled, br_proj;
    logic [1:0]          count;

    // Head entry drives the outputs directly, so they hold once the queue drains.
    logic [LANES-1:0]    head_lv, tail_lv, head_sh, tail_sh;
    logic [32*LANES-1:0] head_pc, tail_pc;
    decode_pkg::dec_t    head_dec [LANES];
    decode_pkg::dec_t    tail_dec [LANES];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        decode_unit u_dec (.instr(in_instr[32*i +: 32]), .dec(lane_dec[i]));
    end

    always_comb begin
        prior_br = 1'b0;
        grp_br   = '0;
        new_sh   = '0;
        new_pc   = '0;
        for (int i = 0; i < LANES; i++) begin
            new_dec[i]          = in_lane_valid[i] ? lane_dec[i] : '0;
            new_pc[32*i +: 32]  = in_pc + 32'(4 * i);
            new_sh[i]           = in_lane_valid[i] && (in_under_shadow || (br_inflight != '0) || prior_br);
            if (in_lane_valid[i] && (lane_dec[i].is_br || lane_dec[i].is_jalr)) begin
                prior_br = 1'b1;
                grp_br   = grp_br + GW'(1);
            end
        end
    end

    assign resolve_eff = br_resolve && (br_inflight != '0);
    assign br_settled  = PW'(br_inflight) - PW'(resolve_eff);
    assign br_proj     = br_settled + PW'(grp_br);
    assign in_ready    = !rst && !flush && (count < 2'd2) && (br_proj <= PW'(MAX_BR));
    assign out_valid   = (count != 2'd0);
    assign accept      = in_valid && in_ready;
    assign pop         = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            br_inflight <= '0;
            head_lv     <= '0;
            tail_lv     <= '0;
            head_sh     <= '0;
            tail_sh     <= '0;
            head_pc     <= '0;
            tail_pc     <= '0;
            // NOTE: queue storage is cleared on reset only because the outputs read straight from it and must be 0 in reset.
            for (int i = 0; i < LANES; i++) begin
                head_dec[i] <= '0;
                tail_dec[i] <= '0;
            end
        end else if (flush) begin
            count       <= '0;
            br_inflight <= '0;
        end else begin
            count       <= count + {1'b0, accept} - {1'b0, pop};
            br_inflight <= BW'(accept ? br_proj : br_settled);
            if (pop && count == 2'd2) begin
                head_lv  <= tail_lv;
                head_sh  <= tail_sh;
                head_pc  <= tail_pc;
                head_dec <= tail_dec;
            end
            if (accept && (count == 2'd0 || pop)) begin
                head_lv  <= in_lane_valid;
                head_sh  <= new_sh;
                head_pc  <= new_pc;
                head_dec <= new_dec;
            end else if (accept) begin
                tail_lv  <= in_lane_valid;
                tail_sh  <= new_sh;
                tail_pc  <= new_pc;
                tail_dec <= new_dec;
            end
        end
    end

    assign out_lane_valid = head_lv;
    assign out_pc         = head_pc;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            out_uopcode[i]    = head_dec[i].uopcode;
            out_iq_type[i]    = head_dec[i].iq_type;
            out_exu_type[i]   = head_dec[i].exu_type;
            out_imm_type[i]   = head_dec[i].imm_type;
            out_has_rd[i]     = head_dec[i].has_rd;
            out_has_rs1[i]    = head_dec[i].has_rs1;
            out_has_rs2[i]    = head_dec[i].has_rs2;
            out_is_br[i]      = head_dec[i].is_br;
            out_is_jal[i]     = head_dec[i].is_jal;
            out_is_jalr[i]    = head_dec[i].is_jalr;
            out_packed_imm[i] = head_dec[i].packed_imm;
            out_shadowed[i]   = head_sh[i];
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reference decode + shadow model feeding a
// scoreboard of expected groups, compared at the queue head every cycle.
module tb_decode_stage;
    localparam int LANES  = 2;
    localparam int MAX_BR = 4;
    localparam int BW     = $clog2(MAX_BR + 1);

    localparam logic [31:0] BEQ = 32'h00208463;  // beq x1,x2,8
    localparam logic [31:0] ADD = 32'h002081B3;  // add x3,x1,x2

    typedef struct packed {
        logic [3:0]  uop;
        logic [1:0]  iq;
        logic [1:0]  exu;
        logic [2:0]  imm;
        logic        has_rd, has_rs1, has_rs2, is_br, is_jal, is_jalr, shadowed;
        logic [19:0] pimm;
    } lane_t;

    typedef struct packed {
        logic [1:0]      lv;
        logic [63:0]     pc;
        lane_t [1:0]     ln;
    } grp_t;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, in_under_shadow, br_resolve, flush, out_valid, out_ready;
    logic [LANES-1:0]     in_lane_valid, out_lane_valid;
    logic [32*LANES-1:0]  in_instr, out_pc;
    logic [31:0]          in_pc;
    uopc::micro_opcode_t  out_uopcode [LANES];
    iqt::queue_type_t     out_iq_type [LANES];
    exut::exe_unit_type_t out_exu_type [LANES];
    immt::imm_type_t      out_imm_type [LANES];
    logic out_has_rd [LANES], out_has_rs1 [LANES], out_has_rs2 [LANES];
    logic out_is_br [LANES], out_is_jal [LANES], out_is_jalr [LANES], out_shadowed [LANES];
    logic [19:0]          out_packed_imm [LANES];
    logic [BW-1:0]        br_inflight;

    int   total = 0, passed = 0, failed = 0;
    int   mdl_br = 0;
    grp_t sb[$];
    grp_t last;
    bit   have_last;

    always #5 clk = ~clk;

    decode_stage #(.LANES(LANES), .MAX_BR(MAX_BR)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_lane_valid(in_lane_valid), .in_instr(in_instr), .in_pc(in_pc),
        .in_under_shadow(in_under_shadow), .br_resolve(br_resolve), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_lane_valid(out_lane_valid),
        .out_pc(out_pc), .out_uopcode(out_uopcode), .out_iq_type(out_iq_type),
        .out_exu_type(out_exu_type), .out_imm_type(out_imm_type), .out_has_rd(out_has_rd),
        .out_has_rs1(out_has_rs1), .out_has_rs2(out_has_rs2), .out_is_br(out_is_br),
        .out_is_jal(out_is_jal), .out_is_jalr(out_is_jalr), .out_shadowed(out_shadowed),
        .out_packed_imm(out_packed_imm), .br_inflight(br_inflight)
    );

    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
    endfunction

    // Reference decode for the instruction kinds this bench issues.
    function automatic lane_t ref_dec(input logic [31:0] ins);
        lane_t r = '0;
        case (ins[6:0])
            7'b0010011: begin
                r.uop = uopc::UOP_ADDI; r.iq = iqt::IQT_INT; r.exu = exut::EXU_ALU; r.imm = immt::IMM_I;
                r.has_rd = 1'b1; r.has_rs1 = 1'b1; r.pimm = {ins[31:20], 8'h00};
            end
            7'b1100011: begin
                r.uop = uopc::UOP_BR; r.iq = iqt::IQT_INT; r.exu = exut::EXU_BRU; r.imm = immt::IMM_B;
                r.has_rs1 = 1'b1; r.has_rs2 = 1'b1; r.is_br = 1'b1; r.pimm = {ins[31:25], ins[11:7], 8'h00};
            end
            7'b0110011: begin
                r.uop = uopc::UOP_ADD; r.iq = iqt::IQT_INT; r.exu = exut::EXU_ALU;
                r.has_rd = 1'b1; r.has_rs1 = 1'b1; r.has_rs2 = 1'b1;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_grp(input string tag, input grp_t e);
        lane_t o;
        chk({tag, ".lane_valid"}, 64'(out_lane_valid), 64'(e.lv));
        chk({tag, ".pc"}, out_pc, e.pc);
        for (int i = 0; i < LANES; i++) begin
            o.uop = out_uopcode[i];   o.iq = out_iq_type[i];   o.exu = out_exu_type[i];
            o.imm = out_imm_type[i];  o.has_rd = out_has_rd[i]; o.has_rs1 = out_has_rs1[i];
            o.has_rs2 = out_has_rs2[i]; o.is_br = out_is_br[i]; o.is_jal = out_is_jal[i];
            o.is_jalr = out_is_jalr[i]; o.shadowed = out_shadowed[i]; o.pimm = out_packed_imm[i];
            chk($sformatf("%s.lane%0d", tag, i), 64'(o), 64'(e.ln[i]));
        end
    endtask

    // One cycle: drive, check against the model, advance the model, clock.
    task automatic step(input logic v, input logic [1:0] lv, input logic [31:0] i0, input logic [31:0] i1,
                        input logic [31:0] pc, input logic sh, input logic res, input logic fl,
                        input logic ordy, input logic exp_rdy);
        grp_t g;
        logic prior = 1'b0;
        int   nbr = 0, dec;
        in_valid = v; in_lane_valid = lv; in_instr = {i1, i0}; in_pc = pc;
        in_under_shadow = sh; br_resolve = res; flush = fl; out_ready = ordy;
        #1;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("br_inflight", 64'(br_inflight), 64'(mdl_br));
        chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        if (sb.size() != 0) cmp_grp("head", sb[0]);
        else if (have_last) cmp_grp("hold", last);

        g.lv = lv;
        g.pc = {pc + 32'd4, pc};
        for (int i = 0; i < LANES; i++) begin
            g.ln[i] = lv[i] ? ref_dec(i == 0 ? i0 : i1) : '0;
            g.ln[i].shadowed = lv[i] && (sh || mdl_br != 0 || prior);
            if (lv[i] && (g.ln[i].is_br || g.ln[i].is_jalr)) begin
                prior = 1'b1;
                nbr++;
            end
        end
        if (fl) begin
            sb.delete();
            mdl_br    = 0;
            have_last = 1'b0;
        end else begin
            dec = (res && mdl_br > 0) ? 1 : 0;
            if (ordy && sb.size() != 0) begin
                last      = sb.pop_front();
                have_last = 1'b1;
            end
            if (v && exp_rdy) begin
                sb.push_back(g);
                mdl_br += nbr;
            end
            mdl_br -= dec;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_lane_valid = '0; in_instr = '0; in_pc = '0;
        in_under_shadow = 1'b0; br_resolve = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst.in_ready", 64'(in_ready), 64'd0);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.br_inflight", 64'(br_inflight), 64'd0);
        cmp_grp("rst", '0);
        rst = 1'b0;
        last = '0;
        have_last = 1'b1;

        // back-to-back ADDI groups at full throughput
        for (int k = 0; k < 6; k++)
            step(1, 2'b11, addi(1, 0, k), addi(2, 1, k + 1), 32'h1000 + 32'(8 * k), 0, 0, 0, 1, 1);
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1);

        // in-group shadow, then resolve the branch
        step(1, 2'b11, BEQ, ADD, 32'h2000, 0, 0, 0, 1, 1);
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 1);

        // branch limit: fill to MAX_BR, refuse, then accept alongside a resolve
        for (int k = 0; k < 4; k++)
            step(1, 2'b01, BEQ, 0, 32'h3000 + 32'(8 * k), 0, 0, 0, 1, 1);
        step(1, 2'b01, BEQ, 0, 32'h3100, 0, 0, 0, 1, 0);
        step(1, 2'b01, BEQ, 0, 32'h3100, 0, 1, 0, 1, 1);
        for (int k = 0; k < 5; k++) step(0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 1);
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1);

        // backpressure: fill the queue, hold, then drain in order
        step(1, 2'b11, addi(4, 0, 11), addi(5, 0, 12), 32'h4000, 0, 0, 0, 0, 1);
        step(1, 2'b11, addi(6, 0, 13), addi(7, 0, 14), 32'h4008, 0, 0, 0, 0, 1);
        step(1, 2'b11, addi(8, 0, 15), addi(9, 0, 16), 32'h4010, 0, 0, 0, 0, 0);
        step(1, 2'b11, addi(8, 0, 15), addi(9, 0, 16), 32'h4010, 0, 0, 0, 0, 0);
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1);

        // flush with a full queue and three branches in flight
        step(1, 2'b11, BEQ, BEQ, 32'h5000, 0, 0, 0, 0, 1);
        step(1, 2'b11, BEQ, addi(1, 0, 3), 32'h5008, 0, 0, 0, 0, 1);
        step(1, 2'b11, addi(1, 0, 1), addi(2, 0, 2), 32'h5010, 0, 1, 1, 0, 0);
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1);

        // pc wrap with only lane 1 valid, under external shadow
        step(1, 2'b10, addi(1, 0, 7), addi(2, 0, 9), 32'hFFFF_FFFC, 1, 0, 0, 1, 1);
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
